// File: rtl/fp_op_scheduler_pkg.sv
// Shared types and constants for the two-port FP operation scheduler.
package fp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int FLG_INEXACT   = 0;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_DIVZERO   = 3;
    localparam int FLG_INVALID   = 4;

    localparam logic [4:0] TIMEOUT_FLAGS = 5'(1) << FLG_INVALID;

    localparam logic [31:0] QNAN_SINGLE = 32'h7FC0_0000;
    localparam logic [31:0] QNAN_HALF   = 32'h0000_7E00;

    // Half-precision values live in the low 16 bits only.
    function automatic logic [31:0] fp_norm(input logic [31:0] v,
                                            input logic mode_fp);
        return mode_fp ? v : {16'h0000, v[15:0]};
    endfunction

endpackage

// File: rtl/fp_op_scheduler_arb.sv
// Combinational two-way round-robin arbiter; the grant pointer lives
// in the parent.
module fp_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    always_comb begin
        gnt_idx_o = (&req_i) ? ~last_grant_i : req_i[1];
        gnt_o     = 2'b00;
        if (en_i) begin
            gnt_o = req_i & (gnt_idx_o ? 2'b10 : 2'b01);
        end
    end

endmodule

// File: rtl/fp_op_scheduler.sv
// Shares one multi-cycle FP execute unit between two requesters with
// round-robin arbitration, issue, timeout and a tagged response channel.
module fp_op_scheduler
    import fp_sched_pkg::*;
#(
    parameter int unsigned EXEC_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  REQ_VALID,
    output logic [1:0]  REQ_READY,
    input  logic [31:0] REQ0_OP_A,
    input  logic [31:0] REQ0_OP_B,
    input  logic [31:0] REQ1_OP_A,
    input  logic [31:0] REQ1_OP_B,
    input  logic [1:0]  REQ0_OP,
    input  logic [1:0]  REQ1_OP,
    input  logic        REQ0_MODE_FP,
    input  logic        REQ1_MODE_FP,
    output logic        EX_START,
    output logic [31:0] EX_OP_A,
    output logic [31:0] EX_OP_B,
    output logic [1:0]  EX_OP,
    output logic        EX_MODE_FP,
    input  logic        EX_DONE,
    input  logic [31:0] EX_RESULT,
    input  logic [4:0]  EX_FLAGS,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic        RSP_ID,
    output logic [31:0] RSP_RESULT,
    output logic [4:0]  RSP_FLAGS,
    output logic        RSP_TIMEOUT
);

    localparam logic [7:0] TMO_LAST = 8'(EXEC_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic        mode_q, mode_d;
    logic        id_q, id_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  flg_q, flg_d;
    logic        tmo_q, tmo_d;

    logic [1:0]  gnt;
    logic        gnt_idx;
    logic        sel_mode;
    logic [1:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    // Ready is suppressed while reset is held so nothing is accepted.
    fp_rr_arb2 u_arb (
        .req_i        (REQ_VALID),
        .last_grant_i (last_q),
        .en_i         ((state_q == ST_IDLE) && !RST),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx)
    );

    assign sel_mode = gnt_idx ? REQ1_MODE_FP : REQ0_MODE_FP;
    assign sel_op   = gnt_idx ? REQ1_OP : REQ0_OP;
    assign sel_a    = gnt_idx ? REQ1_OP_A : REQ0_OP_A;
    assign sel_b    = gnt_idx ? REQ1_OP_B : REQ0_OP_B;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        mode_d  = mode_q;
        id_d    = id_q;
        res_d   = res_q;
        flg_d   = flg_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    id_d    = gnt_idx;
                    mode_d  = sel_mode;
                    op_d    = sel_op;
                    a_d     = fp_norm(sel_a, sel_mode);
                    b_d     = fp_norm(sel_b, sel_mode);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the last allowed cycle beats the timeout.
                if (EX_DONE) begin
                    res_d   = fp_norm(EX_RESULT, mode_q);
                    flg_d   = EX_FLAGS;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    res_d   = mode_q ? QNAN_SINGLE : QNAN_HALF;
                    flg_d   = TIMEOUT_FLAGS;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            mode_q  <= 1'b0;
            id_q    <= 1'b0;
            res_q   <= 32'd0;
            flg_q   <= 5'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            id_q    <= id_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            tmo_q   <= tmo_d;
        end
    end

    assign REQ_READY   = gnt;
    assign EX_START    = (state_q == ST_ISSUE);
    assign EX_OP_A     = a_q;
    assign EX_OP_B     = b_q;
    assign EX_OP       = op_q;
    assign EX_MODE_FP  = mode_q;
    assign RSP_VALID   = (state_q == ST_RESP);
    assign RSP_ID      = id_q;
    assign RSP_RESULT  = res_q;
    assign RSP_FLAGS   = flg_q;
    assign RSP_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_fp_op_scheduler.sv
// Scoreboard bench for fp_op_scheduler with a small execute-unit model.
module tb_fp_op_scheduler;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  REQ_VALID;
    logic [1:0]  REQ_READY;
    logic [31:0] REQ0_OP_A, REQ0_OP_B, REQ1_OP_A, REQ1_OP_B;
    logic [1:0]  REQ0_OP, REQ1_OP;
    logic        REQ0_MODE_FP, REQ1_MODE_FP;
    logic        EX_START;
    logic [31:0] EX_OP_A, EX_OP_B;
    logic [1:0]  EX_OP;
    logic        EX_MODE_FP;
    logic        EX_DONE;
    logic [31:0] EX_RESULT;
    logic [4:0]  EX_FLAGS;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic        RSP_ID;
    logic [31:0] RSP_RESULT;
    logic [4:0]  RSP_FLAGS;
    logic        RSP_TIMEOUT;

    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    assign EX_DONE = model_done | stray_done;

    fp_op_scheduler #(.EXEC_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ0_OP_A(REQ0_OP_A), .REQ0_OP_B(REQ0_OP_B),
        .REQ1_OP_A(REQ1_OP_A), .REQ1_OP_B(REQ1_OP_B),
        .REQ0_OP(REQ0_OP), .REQ1_OP(REQ1_OP),
        .REQ0_MODE_FP(REQ0_MODE_FP), .REQ1_MODE_FP(REQ1_MODE_FP),
        .EX_START(EX_START), .EX_OP_A(EX_OP_A), .EX_OP_B(EX_OP_B),
        .EX_OP(EX_OP), .EX_MODE_FP(EX_MODE_FP),
        .EX_DONE(EX_DONE), .EX_RESULT(EX_RESULT), .EX_FLAGS(EX_FLAGS),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_RESULT(RSP_RESULT), .RSP_FLAGS(RSP_FLAGS),
        .RSP_TIMEOUT(RSP_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    logic        tb_last = 1'b1;
    int          ex_lat = 1;
    logic [31:0] ex_res = 32'd0;
    logic [4:0]  ex_flg = 5'd0;
    logic [31:0] exp_a[2];
    logic [31:0] exp_b[2];
    logic        last_id = 1'b0;
    int          hs_cyc = 0;
    logic        prev_v = 1'b0;

    // Execute-unit model: completes ex_lat cycles after the start pulse.
    initial begin
        EX_RESULT = 32'd0;
        EX_FLAGS  = 5'd0;
        forever begin
            @(negedge CLK);
            if (EX_START && ex_lat > 0) begin
                repeat (ex_lat) @(posedge CLK);
                #1;
                model_done = 1'b1;
                EX_RESULT  = ex_res;
                EX_FLAGS   = ex_flg;
                @(posedge CLK);
                #1;
                model_done = 1'b0;
                EX_RESULT  = 32'hDEAD_BEEF;
                EX_FLAGS   = 5'b11111;
            end
        end
    end

    // Accept watcher: pushes the expected response for every grant.
    always @(negedge CLK) begin : watch
        logic w;
        logic m;
        exp_t e;
        if (!RST && (REQ_READY & REQ_VALID) != 2'b00) begin
            w = (REQ_VALID == 2'b11) ? ~tb_last : REQ_VALID[1];
            chk("ready_onehot", {31'b0, REQ_READY != 2'b11}, 32'd1);
            chk("grant_id", {31'b0, REQ_READY[1]}, {31'b0, w});
            glog.push_back(int'(REQ_READY[1]));
            last_id = w;
            m = w ? REQ1_MODE_FP : REQ0_MODE_FP;
            e.id  = w;
            e.cyc = cyc + 2 + ((ex_lat > 0) ? ex_lat : TMO);
            if (ex_lat > 0) begin
                e.res = m ? ex_res : {16'h0000, ex_res[15:0]};
                e.flg = ex_flg;
                e.tmo = 1'b0;
            end else begin
                e.res = m ? 32'h7FC0_0000 : 32'h0000_7E00;
                e.flg = 5'b10000;
                e.tmo = 1'b1;
            end
            sb.push_back(e);
        end
        if (EX_START) begin
            chk("ex_op_a", EX_OP_A, exp_a[last_id]);
            chk("ex_op_b", EX_OP_B, exp_b[last_id]);
        end
    end

    // Response monitor: pops and compares on each handshake.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (RSP_VALID && !prev_v) begin
            if (sb.size() == 0)
                chk("rsp_unexpected", {31'b0, RSP_VALID}, 32'd0);
            else
                chk("rsp_cycle", 32'(cyc), 32'(sb[0].cyc));
        end
        if (RSP_VALID && RSP_READY && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_id", {31'b0, RSP_ID}, {31'b0, e.id});
            chk("rsp_result", RSP_RESULT, e.res);
            chk("rsp_flags", {27'b0, RSP_FLAGS}, {27'b0, e.flg});
            chk("rsp_timeout", {31'b0, RSP_TIMEOUT}, {31'b0, e.tmo});
            tb_last = e.id;
            hs_cyc  = cyc;
        end
        prev_v = RSP_VALID;
    end

    task automatic wait_sb(input int maxc);
        int k = 0;
        while (sb.size() > 0 && k < maxc) begin
            @(negedge CLK);
            k++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic issue(input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op,
                         input logic mode, input logic [31:0] ea,
                         input logic [31:0] eb);
        int k = 0;
        @(posedge CLK);
        #1;
        exp_a[id] = ea;
        exp_b[id] = eb;
        if (id) begin
            REQ1_OP_A = a; REQ1_OP_B = b;
            REQ1_OP = op; REQ1_MODE_FP = mode;
        end else begin
            REQ0_OP_A = a; REQ0_OP_B = b;
            REQ0_OP = op; REQ0_MODE_FP = mode;
        end
        REQ_VALID[id] = 1'b1;
        do begin
            @(negedge CLK);
            k++;
        end while (!REQ_READY[id] && k < 200);
        chk("issue_accept", {31'b0, REQ_READY[id]}, 32'd1);
        @(posedge CLK);
        #1;
        REQ_VALID[id] = 1'b0;
    endtask

    initial begin : stim
        int n;
        int k;
        int exp_g[4];
        logic [31:0] sres;
        logic [31:0] snap;
        exp_g = '{0, 1, 0, 1};
        RST = 1'b1;
        REQ_VALID = 2'b00;
        REQ0_OP_A = 0; REQ0_OP_B = 0; REQ1_OP_A = 0; REQ1_OP_B = 0;
        REQ0_OP = 0; REQ1_OP = 0; REQ0_MODE_FP = 0; REQ1_MODE_FP = 0;
        RSP_READY = 1'b1;
        exp_a[0] = 0; exp_a[1] = 0; exp_b[0] = 0; exp_b[1] = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_ctl", {18'b0, REQ_READY, EX_START, EX_MODE_FP, EX_OP,
            RSP_VALID, RSP_ID, RSP_TIMEOUT, RSP_FLAGS}, 32'd0);
        chk("reset_ex_ops", EX_OP_A | EX_OP_B, 32'd0);
        chk("reset_rsp_result", RSP_RESULT, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Both requesters valid for four operations.
        glog.delete();
        ex_lat = 1; ex_res = 32'h4049_0FDB; ex_flg = 5'b00001;
        REQ0_OP_A = 32'h3F80_0000; REQ0_OP_B = 32'h4000_0000;
        REQ0_OP = 2'd2; REQ0_MODE_FP = 1'b1;
        exp_a[0] = 32'h3F80_0000; exp_b[0] = 32'h4000_0000;
        REQ1_OP_A = 32'h1234_3C00; REQ1_OP_B = 32'h5678_4400;
        REQ1_OP = 2'd3; REQ1_MODE_FP = 1'b0;
        exp_a[1] = 32'h0000_3C00; exp_b[1] = 32'h0000_4400;
        REQ_VALID = 2'b11;
        n = 0; k = 0;
        while (n < 4 && k < 200) begin
            @(negedge CLK);
            k++;
            if ((REQ_READY & REQ_VALID) != 2'b00) n++;
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 2'b00;
        chk("arb_accepts", 32'(n), 32'd4);
        wait_sb(100);
        chk("arb_glog_size", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk("arb_grant_order", 32'(glog[i]), 32'(exp_g[i]));

        // Half-mode add, L=3.
        ex_lat = 3; ex_res = 32'h0000_4200; ex_flg = 5'd0;
        issue(1'b0, 32'hFFFF_3C00, 32'h0000_4000, 2'd0, 1'b0,
              32'h0000_3C00, 32'h0000_4000);
        wait_sb(100);

        // Half-mode result with junk in the upper half.
        ex_lat = 2; ex_res = 32'hABCD_1234; ex_flg = 5'b00001;
        issue(1'b1, 32'h0000_3C00, 32'h0000_3C00, 2'd2, 1'b0,
              32'h0000_3C00, 32'h0000_3C00);
        wait_sb(100);

        // Response back-pressure for five cycles.
        RSP_READY = 1'b0;
        ex_lat = 1; ex_res = 32'h4040_0000; ex_flg = 5'd0;
        issue(1'b0, 32'h3F80_0000, 32'h4000_0000, 2'd0, 1'b1,
              32'h3F80_0000, 32'h4000_0000);
        k = 0;
        while (!RSP_VALID && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("hold_rsp_seen", {31'b0, RSP_VALID}, 32'd1);
        sres = RSP_RESULT;
        snap = {24'b0, 1'b1, RSP_ID, RSP_TIMEOUT, RSP_FLAGS};
        @(posedge CLK);
        #1;
        REQ0_OP_A = 32'h4000_0000; REQ0_OP_B = 32'h4040_0000;
        REQ0_OP = 2'd1; REQ0_MODE_FP = 1'b1;
        exp_a[0] = 32'h4000_0000; exp_b[0] = 32'h4040_0000;
        REQ_VALID[0] = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            chk("hold_result", RSP_RESULT, sres);
            chk("hold_ctl", {24'b0, RSP_VALID, RSP_ID, RSP_TIMEOUT,
                RSP_FLAGS}, snap);
            chk("hold_no_ready", {30'b0, REQ_READY}, 32'd0);
        end
        @(posedge CLK);
        #1;
        RSP_READY = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!REQ_READY[0] && k < 50);
        chk("accept_after_hs", 32'(cyc), 32'(hs_cyc + 1));
        @(posedge CLK);
        #1;
        REQ_VALID[0] = 1'b0;
        wait_sb(100);

        // Timeout, single mode, then a stray completion.
        ex_lat = 0;
        issue(1'b0, 32'h3F80_0000, 32'h3F80_0000, 2'd3, 1'b1,
              32'h3F80_0000, 32'h3F80_0000);
        wait_sb(100);
        @(posedge CLK);
        #1;
        stray_done = 1'b1;
        @(posedge CLK);
        #1;
        stray_done = 1'b0;
        repeat (4) @(negedge CLK);
        chk("stray_no_rsp", {31'b0, RSP_VALID}, 32'd0);

        // Reset during WAIT, then requester 1 alone.
        ex_lat = 0;
        issue(1'b0, 32'h3F80_0000, 32'h4000_0000, 2'd0, 1'b1,
              32'h3F80_0000, 32'h4000_0000);
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        ex_lat = 2; ex_res = 32'h0000_3800; ex_flg = 5'd0;
        REQ1_OP_A = 32'hFFFF_4400; REQ1_OP_B = 32'h0000_3C00;
        REQ1_OP = 2'd1; REQ1_MODE_FP = 1'b0;
        exp_a[1] = 32'h0000_4400; exp_b[1] = 32'h0000_3C00;
        REQ_VALID = 2'b10;
        @(negedge CLK);
        chk("rst_no_ready", {30'b0, REQ_READY}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();
        tb_last = 1'b1;
        @(negedge CLK);
        chk("rst_clear_ctl", {20'b0, EX_START, EX_MODE_FP, EX_OP,
            RSP_VALID, RSP_ID, RSP_TIMEOUT, RSP_FLAGS}, 32'd0);
        chk("rst_clear_data", EX_OP_A | EX_OP_B | RSP_RESULT, 32'd0);
        chk("rst_req1_ready", {30'b0, REQ_READY}, 32'd2);
        @(posedge CLK);
        #1;
        REQ_VALID = 2'b00;
        wait_sb(100);

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_op_scheduler.md
# fp_op_scheduler

Two-port scheduler that shares one multi-cycle floating-point execute unit between two requesters. It arbitrates requests round-robin, latches and width-normalises the operands for the selected format (half or single), and issues a one-cycle start pulse to the execute unit. It then waits for completion, with a timeout, and returns the result on a valid/ready response channel tagged with the requester ID. It sits between the issuing front-ends and the FP datapath, whose decode stage consumes OP_A/OP_B/MODE_FP.

## Interface
- EXEC_TIMEOUT, 64: WAIT cycles allowed before the operation is aborted; legal range 2..255.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ_VALID  in  2  request valid, bit i = requester i.
- REQ_READY  out  2  request accepted (one-hot or zero).
- REQ0_OP_A, REQ0_OP_B / REQ1_OP_A, REQ1_OP_B  in  32 each  operands.
- REQ0_OP / REQ1_OP  in  2  opcode: 0 add, 1 sub, 2 mul, 3 div.
- REQ0_MODE_FP / REQ1_MODE_FP  in  1  0 = half, 1 = single.
- EX_START  out  1  one-cycle issue pulse.
- EX_OP_A, EX_OP_B  out  32  latched, normalised operands.
- EX_OP  out  2  latched opcode.
- EX_MODE_FP  out  1  latched format.
- EX_DONE  in  1  completion pulse from the execute unit.
- EX_RESULT  in  32  result; sampled only on EX_DONE.
- EX_FLAGS  in  5  {invalid, divzero, overflow, underflow, inexact}.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumed.
- RSP_ID  out  1  requester that owns the response.
- RSP_RESULT  out  32  result.
- RSP_FLAGS  out  5  flags.
- RSP_TIMEOUT  out  1  operation was aborted on timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - REQ_READY[g] = REQ_VALID[g] for the arbiter winner g; the other ready bit is 0. Ready is combinational from state and valid.
  - Round-robin: if both requesters are valid, the one that is not last_grant wins. A single valid requester always wins.
  - On accept, latch opcode, mode and operands, and go to ISSUE.
  - Half mode: latched operands have bits [31:16] forced to 0.
- ISSUE
  - EX_START=1 for exactly this cycle.
  - Clear the wait counter and go to WAIT.
- WAIT
  - EX_DONE=1: capture EX_RESULT and EX_FLAGS, set RSP_TIMEOUT=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches EXEC_TIMEOUT-1 with no EX_DONE, go to RESP with the following values:
    - RSP_RESULT = canonical qNaN: 32'h7FC0_0000 in single mode, 32'h0000_7E00 in half mode.
    - RSP_FLAGS = 5'b10000.
    - RSP_TIMEOUT = 1.
  - EX_DONE on the final allowed cycle wins over the timeout.
- RESP
  - RSP_VALID is held high and all RSP_* fields are stable until RSP_READY.
  - On the handshake, last_grant is set to RSP_ID and the FSM returns to IDLE.
- Half-mode responses always have RSP_RESULT[31:16]=0, including when EX_RESULT is non-zero there.
- EX_DONE outside WAIT is ignored. A late EX_DONE after a timeout is ignored and no second response is issued.
- EX_OP_A, EX_OP_B, EX_OP and EX_MODE_FP hold their latched values from ISSUE until the next accept.

## Timing
- Reset values:
  - State IDLE, last_grant=1, so requester 0 wins first.
  - All outputs 0, including REQ_READY, EX_START, EX_* data and all RSP_* outputs.
- RST asserted mid-operation abandons the operation: no response is produced, EX_START is 0 from the next cycle, and no REQ_READY is asserted while RST is high.
- Latency, with accept at cycle T:
  - EX_START at T+1.
  - If EX_DONE arrives at T+1+L (L≥1), RSP_VALID rises at T+2+L.
  - On timeout, RSP_VALID rises at T+2+EXEC_TIMEOUT.
- Throughput: at most one operation in flight. The next accept can occur no earlier than the cycle after the RSP handshake.
- Requests are never dropped. An unaccepted requester must hold REQ_VALID and its data.

## Structure
- Package fp_sched_pkg holds:
  - the state enum;
  - opcode constants;
  - flag bit indices;
  - QNAN_SINGLE = 32'h7FC0_0000 and QNAN_HALF = 32'h0000_7E00.
- Sub-module fp_rr_arb2: inputs are the two request bits, last_grant and an enable; outputs are the one-hot grant and the grant index. It is purely combinational. The pointer register stays in the parent.

## Test plan
- Single half-mode add on requester 0:
  - Stimulus: OP_A=32'hFFFF_3C00, OP_B=32'h0000_4000; execute model returns 32'h0000_4200 after L=3.
  - Required: EX_OP_A=32'h0000_3C00; RSP_VALID at T+5; RSP_ID=0; RSP_RESULT=32'h0000_4200.
- Both requesters valid every cycle for 4 operations, RSP_READY tied high:
  - Required: grants 0,1,0,1; REQ_READY never 2'b11.
- Execute unit never asserts EX_DONE, EXEC_TIMEOUT=8, single mode:
  - Required: RSP_VALID at T+10; RSP_RESULT=32'h7FC0_0000; RSP_FLAGS=5'b10000; RSP_TIMEOUT=1.
  - A later stray EX_DONE causes no further response.
- RSP_READY held low for 5 cycles:
  - Required: RSP_* fields are stable throughout and REQ_READY stays 0; the next accept occurs one cycle after the handshake.
- RST pulsed during WAIT:
  - Required: all outputs 0 the following cycle; no response for the abandoned operation; the next request from requester 1 alone is accepted normally.
- Half-mode response with EX_RESULT=32'hABCD_1234:
  - Required: RSP_RESULT=32'h0000_1234.
